matrix_scan_ctrl: RTL
=====================

Name: matrix_scan_ctrl

Overview:
Column-scan sequencer for the 8x8 LED matrix. It generates the 3-bit column index that feeds the column one-hot decoder, plus a column-enable gate and the 8-bit row pattern for the active column. It holds a double-buffered 8x8 frame store that the host writes, and applies per-column PWM brightness and an anti-ghosting guard interval. It sits between the host/register interface and the column decoder and row drivers.

Parameters:
DWELL_W, 8, width of the prescaler reload value (dwell_cycles)
BLANK_CYCLES, 2, guard clocks per column with all drive off; legal range is 1 to 15

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  scan enable; when low, the scanner idles
dwell_cycles  in  DWELL_W  prescaler reload; one tick = dwell_cycles+1 clocks
brightness  in  4  on-ticks per column slot, range 0 to 15
wr_en  in  1  write one row pattern into the back buffer
wr_addr  in  3  column index for the write
wr_data  in  8  row pattern for the write
swap_req  in  1  pulse; request a front/back buffer swap at the next frame boundary
swap_pending  out  1  swap has been requested but not yet performed
col_counter  out  3  column index driven to the column decoder
col_en  out  1  column drive enable; decoder output is qualified by this
row_out  out  8  row pattern for the active column; 0 whenever col_en=0
frame_start  out  1  one-clock pulse on LOAD of column 0

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. col_counter=0, col_en=0, row_out=0, frame_start=0, swap_pending=0, front buffer select=0. Both buffer contents are cleared to 0.
- States: IDLE, LOAD, ON, OFF, GUARD.
- IDLE: all outputs are 0. When ena=1, go to LOAD with col_counter=0.
- LOAD (1 clk, col_en=0):
  - Latch the front-buffer entry [col_counter] into the row register.
  - Sample brightness into b and clear the prescaler and tick counter.
  - frame_start=1 if col_counter=0.
  - Next state is ON if b>0, else OFF.
- ON: col_en=1 and row_out=row register, for exactly b*(dwell_cycles+1) clocks. Then go to OFF.
- OFF: col_en=0 and row_out=0, for (16-b)*(dwell_cycles+1) clocks. Then go to GUARD.
- GUARD: col_en=0, for BLANK_CYCLES clocks. On exit, col_counter increments mod 8 (7 wraps to 0), then go to LOAD.
- col_counter changes only on the GUARD->LOAD transition or on reset/IDLE. It is never changed while col_en=1.
- Slot length is 1 + 16*(dwell_cycles+1) + BLANK_CYCLES clocks, independent of brightness. A frame is 8 slots.
- Prescaler: counts 0..dwell_cycles and ticks on terminal count. dwell_cycles is sampled at LOAD. A change mid-slot takes effect in the next slot.
- Writes: when wr_en=1, the back buffer entry [wr_addr] <= wr_data. Writes are accepted in every state, including IDLE. The front buffer is never written.
- Swap:
  - swap_req=1 sets swap_pending.
  - On the GUARD->LOAD transition where col_counter wraps 7->0, if swap_pending=1: toggle the front select and clear swap_pending. The following LOAD of column 0 reads the new front buffer.
  - Simultaneous swap_req and swap in the same cycle: the swap happens and swap_pending stays 1, so the request carries to the next frame.
  - Simultaneous wr_en and swap: the write lands in the pre-swap back buffer, which becomes the new front.
- ena deasserted in any state: next clk enters IDLE with outputs forced to 0 and col_counter=0. swap_pending and buffer contents are preserved.
- Reset mid-operation: same as the reset values above, taking effect on the same edge.

Decomposition:
- Shared package matrix_pkg: state enum (IDLE, LOAD, ON, OFF, GUARD), MATRIX_COLS=8, COL_IDX_W=3, ROW_W=8, BRIGHT_W=4, SLOT_TICKS=16.
- One sub-module, matrix_frame_buf: 2x8x8 storage, write port to the back buffer, read port from the front buffer, front-select toggle.
- The FSM, prescaler and counters live in matrix_scan_ctrl.

Test Plan:
1. Reset, then ena=1, dwell_cycles=0, brightness=8, no writes -> frame_start at the first LOAD. Each slot is 19 clocks with col_en high for 8 clocks. col_counter runs 0..7 then 0, and row_out=0 throughout.
2. Write col3=0xA5 then swap_req, with dwell_cycles=1 and brightness=15 -> the swap happens at the next 7->0 wrap and swap_pending drops. In column 3, row_out=0xA5 with col_en high for 30 clocks, then 2 off clocks, then 2 guard clocks.
3. brightness=0 -> col_en never asserts and row_out stays 0. brightness changed mid-slot from 4 to 12 -> the current slot keeps 4 on-ticks and the next slot uses 12.
4. swap_req issued on the exact swap cycle -> one swap now and swap_pending=1 afterwards. The second swap occurs one frame later.
5. wr_en to col0=0xFF on the swap cycle -> the next column-0 LOAD shows row_out=0xFF.
6. ena dropped during ON -> next clk: col_en=0, row_out=0, col_counter=0. ena reasserted -> restart at column 0 with frame_start. rst_n=0 mid-ON -> all outputs reset on that edge.

Source files
------------

// File: rtl/matrix_pkg.sv
// ============================================================================
// Module      : matrix_pkg
// Description : Shared types and sizing constants for the 8x8 LED matrix
//               column-scan sequencer and its frame store.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

    localparam int MATRIX_COLS = 8;
    localparam int COL_IDX_W   = 3;
    localparam int ROW_W       = 8;
    localparam int BRIGHT_W    = 4;
    localparam int SLOT_TICKS  = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ON    = 3'd2,
        OFF   = 3'd3,
        GUARD = 3'd4
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/matrix_frame_buf.sv
// ============================================================================
// Module      : matrix_frame_buf
// Description : Double-buffered 8x8 frame store. Host writes go to the back
//               buffer, the scanner reads the front buffer; swap flips them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_frame_buf
    import matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [COL_IDX_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]     wr_data,
    input  logic [COL_IDX_W-1:0] rd_addr,
    output logic [ROW_W-1:0]     rd_data,
    input  logic                 swap
);

    logic [ROW_W-1:0] mem_q [2][MATRIX_COLS];
    logic [ROW_W-1:0] mem_d [2][MATRIX_COLS];
    logic             front_q;
    logic             front_d;
    logic             back_sel;

    assign back_sel = ~front_q;

    // A write coinciding with a swap lands in the old back buffer, which is
    // the buffer that becomes front on the same edge.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[back_sel][wr_addr] = wr_data;
        end
        front_d = front_q ^ swap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            front_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            front_q <= front_d;
        end
    end

    assign rd_data = mem_q[front_q][rd_addr];

endmodule

`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
// ============================================================================
// Module      : matrix_scan_ctrl
// Description : Column-scan sequencer for an 8x8 LED matrix with per-column
//               PWM brightness, anti-ghosting guard and frame-aligned swap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_scan_ctrl
    import matrix_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DWELL_W-1:0]   dwell_cycles,
    input  logic [BRIGHT_W-1:0]  brightness,
    input  logic                 wr_en,
    input  logic [COL_IDX_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]     wr_data,
    input  logic                 swap_req,
    output logic                 swap_pending,
    output logic [COL_IDX_W-1:0] col_counter,
    output logic                 col_en,
    output logic [ROW_W-1:0]     row_out,
    output logic                 frame_start
);

    localparam logic [3:0]           GUARD_LAST = 4'(BLANK_CYCLES - 1);
    localparam logic [BRIGHT_W-1:0]  TICK_LAST  = BRIGHT_W'(SLOT_TICKS - 1);
    localparam logic [COL_IDX_W-1:0] COL_LAST   = COL_IDX_W'(MATRIX_COLS - 1);

    scan_state_e          state_q, state_d;
    logic [COL_IDX_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [BRIGHT_W-1:0]  bright_q, bright_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [DWELL_W-1:0]   presc_q, presc_d;
    logic [BRIGHT_W-1:0]  tick_q, tick_d;
    logic [3:0]           guard_q, guard_d;
    logic                 pend_q, pend_d;

    logic                 tick;
    logic                 on_done;
    logic                 off_done;
    logic                 guard_done;
    logic                 do_swap;
    logic [ROW_W-1:0]     fb_rd_data;

    matrix_frame_buf u_frame_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (col_q),
        .rd_data (fb_rd_data),
        .swap    (do_swap)
    );

    // The tick counter runs across ON and OFF, so a slot is always 16 ticks.
    assign tick       = (presc_q == dwell_q);
    assign on_done    = tick && ((tick_q + 1'b1) == bright_q);
    assign off_done   = tick && (tick_q == TICK_LAST);
    assign guard_done = (guard_q == GUARD_LAST);
    assign do_swap    = ena && (state_q == GUARD) && guard_done
                        && (col_q == COL_LAST) && pend_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            bright_q <= '0;
            dwell_q  <= '0;
            presc_q  <= '0;
            tick_q   <= '0;
            guard_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            bright_q <= bright_d;
            dwell_q  <= dwell_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            guard_q  <= guard_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = LOAD;
                LOAD:    state_d = (brightness != '0) ? ON : OFF;
                ON:      if (on_done)    state_d = OFF;
                OFF:     if (off_done)   state_d = GUARD;
                GUARD:   if (guard_done) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    // A request arriving on the swap edge itself survives for the next frame.
    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        bright_d = bright_q;
        dwell_d  = dwell_q;
        presc_d  = presc_q;
        tick_d   = tick_q;
        guard_d  = guard_q;
        pend_d   = swap_req | (pend_q & ~do_swap);
        if (!ena || (state_q == IDLE)) begin
            col_d = '0;
        end else begin
            case (state_q)
                LOAD: begin
                    row_d    = fb_rd_data;
                    bright_d = brightness;
                    dwell_d  = dwell_cycles;
                    presc_d  = '0;
                    tick_d   = '0;
                end
                ON, OFF: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        tick_d = tick_q + 1'b1;
                    end
                    guard_d = '0;
                end
                GUARD: begin
                    guard_d = guard_q + 1'b1;
                    if (guard_done) begin
                        col_d = col_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        col_en       = (state_q == ON);
        row_out      = col_en ? row_q : '0;
        frame_start  = (state_q == LOAD) && (col_q == '0);
        col_counter  = col_q;
        swap_pending = pend_q;
    end

endmodule

`default_nettype wire
